// File: rtl/mem_stage_bhw.sv
// MEM stage: byte-addressed data memory with byte/half/word access, load extension,
// misalignment detection and the MEM/WB register. `MEM_DEBUG_PORT_EN adds a word-read debug port.
module mem_stage_bhw #(
    parameter int DATA_W     = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int REG_ADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         reset,
`ifdef MEM_DEBUG_PORT_EN
    input  logic [$clog2(MEM_DEPTH)-1:0] i_debug_addr,
    output logic [DATA_W-1:0]            o_debug_data,
`endif
    input  logic                         i_enable,
    input  logic [DATA_W-1:0]            i_ALU_res,
    input  logic [DATA_W-1:0]            i_rt_reg,
    input  logic [REG_ADDR_W-1:0]        i_addr_reg_dst,
    input  logic                         is_RegWrite,
    input  logic                         is_MemtoReg,
    input  logic                         is_MemWrite,
    input  logic                         is_MemRead,
    input  logic [1:0]                   is_size,
    input  logic                         is_unsigned,
    output logic [DATA_W-1:0]            o_output_mem,
    output logic [DATA_W-1:0]            o_ALU_res,
    output logic [REG_ADDR_W-1:0]        o_addr_reg_dst,
    output logic                         os_RegWrite,
    output logic                         os_MemtoReg,
    output logic                         o_misaligned
);

    localparam int         IDX_W   = $clog2(MEM_DEPTH);
    localparam int         LANES   = DATA_W / 8;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [IDX_W-1:0]  word_idx_p0;
    logic [1:0]        lane_p0;
    logic              mem_access_p0;
    logic              misaligned_p0;
    logic              do_store_p0;
    logic [DATA_W-1:0] rd_word_p0;
    logic [DATA_W-1:0] load_data_p0;
    logic [DATA_W-1:0] wr_data_p0;
    logic [LANES-1:0]  wr_be_p0;
    logic              unused_addr_bits;

    // Pick the addressed lane(s) out of the word and widen to DATA_W.
    function automatic logic [DATA_W-1:0] extend_load(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        lane,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [DATA_W-1:0]        shifted;
        logic signed [7:0]        b;
        logic signed [15:0]       h;
        logic signed [DATA_W-1:0] sx;
        shifted = word >> {lane, 3'b000};
        b = shifted[7:0];
        h = shifted[15:0];
        if (size == SZ_BYTE) begin
            if (uns) return DATA_W'(shifted[7:0]);
            sx = b;
            return sx;
        end else if (size == SZ_HALF) begin
            if (uns) return DATA_W'(shifted[15:0]);
            sx = h;
            return sx;
        end
        return word;
    endfunction

    assign word_idx_p0      = i_ALU_res[IDX_W+1:2];
    assign lane_p0          = i_ALU_res[1:0];
    assign unused_addr_bits = ^i_ALU_res[DATA_W-1:IDX_W+2];

    assign mem_access_p0 = is_MemWrite | is_MemRead;
    assign misaligned_p0 = mem_access_p0 &
                           (((is_size == SZ_HALF) & lane_p0[0]) |
                            (is_size[1] & (lane_p0 != 2'b00)));
    assign do_store_p0   = ~reset & i_enable & is_MemWrite & ~misaligned_p0;

    // Read happens before the edge, so a simultaneous store is seen only by later loads.
    assign rd_word_p0   = mem[word_idx_p0];
    assign load_data_p0 = extend_load(rd_word_p0, lane_p0, is_size, is_unsigned);

    always_comb begin
        wr_data_p0 = i_rt_reg;
        wr_be_p0   = '1;
        case (is_size)
            SZ_BYTE: begin
                wr_data_p0 = {LANES{i_rt_reg[7:0]}};
                wr_be_p0   = LANES'(1) << lane_p0;
            end
            SZ_HALF: begin
                wr_data_p0 = {(LANES/2){i_rt_reg[15:0]}};
                wr_be_p0   = LANES'(2'b11) << {lane_p0[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_store_p0) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be_p0[i]) mem[word_idx_p0][8*i +: 8] <= wr_data_p0[8*i +: 8];
            end
        end
    end

`ifdef MEM_DEBUG_PORT_EN
    assign o_debug_data = mem[i_debug_addr];
`endif

    // ---- p0 -> p1 : MEM/WB register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            o_output_mem   <= '0;
            o_ALU_res      <= '0;
            o_addr_reg_dst <= '0;
            os_RegWrite    <= 1'b0;
            os_MemtoReg    <= 1'b0;
            o_misaligned   <= 1'b0;
        end else if (i_enable) begin
            o_output_mem   <= (is_MemRead && !misaligned_p0) ? load_data_p0 : '0;
            o_ALU_res      <= i_ALU_res;
            o_addr_reg_dst <= i_addr_reg_dst;
            os_RegWrite    <= is_RegWrite & ~misaligned_p0;
            os_MemtoReg    <= is_MemtoReg;
            o_misaligned   <= misaligned_p0;
        end
    end

endmodule
